// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, validated up front, with a
// fixed ACCESS/CAPTURE/RESP sequence and an extended load result or exception.
module mem_access_unit #(
  parameter int unsigned SIZE = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_exc,
  output logic              mem_en,
  output logic              mem_wr_rd,
  output logic [SIZE+2:0]   mem_addr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_data_out,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_exception
);

  localparam int unsigned AW = SIZE + 3;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_FAULT    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      exc_q, exc_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic [31:0]     mem_data_out_q, mem_data_out_d;

  logic            accept;
  logic            illegal;
  logic            misaligned;
  logic            out_of_range;
  logic [1:0]      req_exc;
  logic            req_err;
  logic [31:0]     wdata_masked;
  logic [31:0]     load_ext;

  assign accept = req_valid && (state_q == S_IDLE);

  // Request validation; priority is illegal > misaligned > out of range.
  always_comb begin
    illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_funct3[2] && req_store);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = |(req_addr >> AW);
    if (illegal)           req_exc = EXC_ILLEGAL;
    else if (misaligned)   req_exc = EXC_MISALIGN;
    else if (out_of_range) req_exc = EXC_FAULT;
    else                   req_exc = EXC_NONE;
    req_err = (req_exc != EXC_NONE);
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   wdata_masked = {24'h0, req_wdata[7:0]};
      2'b01:   wdata_masked = {16'h0, req_wdata[15:0]};
      default: wdata_masked = req_wdata;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_data_in[7]}}, mem_data_in[7:0]};
      3'b001:  load_ext = {{16{mem_data_in[15]}}, mem_data_in[15:0]};
      3'b100:  load_ext = {24'h0, mem_data_in[7:0]};
      3'b101:  load_ext = {16'h0, mem_data_in[15:0]};
      default: load_ext = mem_data_in;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_valid) state_d = req_err ? S_RESP : S_ACCESS;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (resp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      store_q        <= 1'b0;
      funct3_q       <= '0;
      rdata_q        <= '0;
      exc_q          <= EXC_NONE;
      mem_addr_q     <= '0;
      mem_size_q     <= '0;
      mem_data_out_q <= '0;
    end else begin
      store_q        <= store_d;
      funct3_q       <= funct3_d;
      rdata_q        <= rdata_d;
      exc_q          <= exc_d;
      mem_addr_q     <= mem_addr_d;
      mem_size_q     <= mem_size_d;
      mem_data_out_q <= mem_data_out_d;
    end
  end

  // Memory-side fields only move on a request that will really issue a cycle,
  // so they hold their last value through rejected requests.
  always_comb begin
    store_d        = store_q;
    funct3_d       = funct3_q;
    rdata_d        = rdata_q;
    exc_d          = exc_q;
    mem_addr_d     = mem_addr_q;
    mem_size_d     = mem_size_q;
    mem_data_out_d = mem_data_out_q;
    if (accept) begin
      store_d  = req_store;
      funct3_d = req_funct3;
      rdata_d  = '0;
      exc_d    = req_exc;
      if (!req_err) begin
        mem_addr_d     = req_addr[AW-1:0];
        mem_size_d     = req_funct3[1:0];
        mem_data_out_d = wdata_masked;
      end
    end else if (state_q == S_CAPTURE) begin
      if (mem_exception) begin
        exc_d   = EXC_FAULT;
        rdata_d = '0;
      end else begin
        exc_d   = EXC_NONE;
        rdata_d = store_q ? '0 : load_ext;
      end
    end
  end

  // Output logic
  always_comb begin
    req_ready    = RST_N && (state_q == S_IDLE);
    resp_valid   = (state_q == S_RESP);
    mem_en       = (state_q == S_ACCESS);
    mem_wr_rd    = (state_q == S_ACCESS) && store_q;
    resp_rdata   = rdata_q;
    resp_exc     = exc_q;
    mem_addr     = mem_addr_q;
    mem_size     = mem_size_q;
    mem_data_out = mem_data_out_q;
  end

endmodule
